// File: rtl/pong_renderer.sv
// pong_renderer
//   Playfield renderer with built-in VGA timing. Produces hsync/vsync and a
//   6-bit rrggbb pixel stream that shows a ball and two paddles on a
//   2**GRID_LOG2 x 2**GRID_LOG2 cell grid, each cell 2**CELL_LOG2 pixels wide.
//   Ball and paddle inputs are captured once per frame, at the first cycle of
//   the vertical front porch, so the game core can update them at any time
//   without tearing. Colours are used live.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high
//   ball_x/y     ball cell column/row
//   lpaddle      bit r set -> left paddle occupies row r (drawn in the last column)
//   rpaddle      bit r set -> right paddle occupies row r (drawn in column 0)
//   bgcolor      playfield/background colour
//   fgcolor      ball/paddle colour
//   hsync/vsync  sync outputs, active level given by SYNC_POL
//   rrggbb       pixel colour, 0 during blanking
//   frame_start  one-cycle pulse on the first cycle of vertical front porch
//
// All outputs are registered, one cycle behind the counters, and mutually aligned.
//
// Build option
//   RENDER_BORDER_EN  when defined, a one-pixel fgcolor frame is drawn on the
//                     active pixels immediately surrounding the playfield.

module pong_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 64,
    parameter int H_BP      = 120,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 16,
    parameter int SYNC_POL  = 0,
    parameter int GRID_LOG2 = 5,
    parameter int CELL_LOG2 = 3,
    parameter int X_OFFSET  = 192,
    parameter int Y_OFFSET  = 112
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GRID_LOG2-1:0]      ball_x,
    input  logic [GRID_LOG2-1:0]      ball_y,
    input  logic [2**GRID_LOG2-1:0]   lpaddle,
    input  logic [2**GRID_LOG2-1:0]   rpaddle,
    input  logic [5:0]                bgcolor,
    input  logic [5:0]                fgcolor,
    output logic                      hsync,
    output logic                      vsync,
    output logic [5:0]                rrggbb,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PF      = 2**(GRID_LOG2 + CELL_LOG2);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_OFF    = HW'(X_OFFSET);
    localparam logic [HW-1:0] PF_H     = HW'(PF);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_OFF    = VW'(Y_OFFSET);
    localparam logic [VW-1:0] PF_V     = VW'(PF);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0]             hcnt;
    logic [VW-1:0]             vcnt;
    logic [GRID_LOG2-1:0]      ball_x_q;
    logic [GRID_LOG2-1:0]      ball_y_q;
    logic [2**GRID_LOG2-1:0]   lpaddle_q;
    logic [2**GRID_LOG2-1:0]   rpaddle_q;

    logic [HW-1:0]             xp;
    logic [VW-1:0]             yp;
    logic [GRID_LOG2-1:0]      cx;
    logic [GRID_LOG2-1:0]      cy;
    logic                      in_field;
    logic                      fg_pix;
    logic                      active;
    logic                      hs_on;
    logic                      vs_on;
    logic                      snap;

    always_comb begin
        // Pixels left of / above the offset wrap to large values and so fail
        // the "< PF" test without needing a separate lower-bound compare.
        xp       = hcnt - X_OFF;
        yp       = vcnt - Y_OFF;
        cx       = xp[CELL_LOG2 +: GRID_LOG2];
        cy       = yp[CELL_LOG2 +: GRID_LOG2];
        in_field = (xp < PF_H) && (yp < PF_V);

        fg_pix = in_field &&
                 ((cx == ball_x_q && cy == ball_y_q) ||
                  (cx == '1 && lpaddle_q[cy]) ||
                  (cx == '0 && rpaddle_q[cy]));

`ifdef RENDER_BORDER_EN
        // xp/yp == '1 is the pixel just before the playfield (offset - 1).
        if (((xp == '1 || xp == PF_H) && (yp == '1 || yp <= PF_V)) ||
            ((yp == '1 || yp == PF_V) && (xp == '1 || xp <= PF_H)))
            fg_pix = 1'b1;
`endif

        active = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_on  = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_on  = (vcnt >= VS_BEG) && (vcnt < VS_END);
        snap   = (hcnt == '0) && (vcnt == V_ACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            lpaddle_q   <= '0;
            rpaddle_q   <= '0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            rrggbb      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST)
                    vcnt <= '0;
                else
                    vcnt <= vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end

            if (snap) begin
                ball_x_q  <= ball_x;
                ball_y_q  <= ball_y;
                lpaddle_q <= lpaddle;
                rpaddle_q <= rpaddle;
            end

            frame_start <= snap;
            hsync       <= hs_on ? SYNC_ON : ~SYNC_ON;
            vsync       <= vs_on ? SYNC_ON : ~SYNC_ON;
            if (active)
                rrggbb <= fg_pix ? fgcolor : bgcolor;
            else
                rrggbb <= '0;
        end
    end

endmodule
